// File: rtl/moonbase_bus_responder.sv
// Memory-side responder for the moonbase_cpu_4bit multiplexed nibble bus: address latch, 128x4 store, output-strobe capture FIFO.
// Latency: reads are combinational (zero cycles); writes and FIFO pushes take effect on the next rising edge.
// Backpressure: the CPU is never stalled; a strobe arriving while the FIFO is full (and not popping) is dropped and sets out_ovf.
//
// Ports:
//   clk, rst                          - system clock, asynchronous active-high reset
//   bus_in[7:0]                       - CPU io_out: [7]=address phase, [6:0]=address; in data phase
//                                       [3:0]=data, [4]=output strobe (high), [5]=write strobe (low)
//   rdata[3:0]                        - read nibble back to the CPU (combinational)
//   load_en, load_addr, load_data     - host preload write port (wins over a same-cycle CPU write)
//   out_data, out_valid, out_ready    - captured-nibble FIFO, valid/ready pop
//   out_ovf                           - sticky: a captured nibble was dropped
//   wp_err                            - sticky write-protect violation
//
// Optional feature macro: RESP_WRPROT_EN -- CPU writes below PROT_LIMIT are suppressed and flag wp_err.
// Without it, every CPU write commits and wp_err is tied low.

module moonbase_bus_responder #(
    parameter int             AW         = 7,
    parameter int             FIFO_DEPTH = 4,
    parameter logic [AW-1:0]  PROT_LIMIT = 7'h60
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    bus_in,
    output logic [3:0]    rdata,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [3:0]    load_data,
    output logic [3:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_ovf,
    output logic          wp_err
);

    localparam int PW = $clog2(FIFO_DEPTH);

    // Storage (deliberately not reset: program contents survive a mid-run reset)
    logic [3:0]    mem      [0:(1<<AW)-1];
    logic [3:0]    fifo_mem [0:FIFO_DEPTH-1];

    logic [AW-1:0] addr_q;
    logic          wr_prev_q;
    logic          os_prev_q;
    logic [PW:0]   wr_ptr_q;
    logic [PW:0]   rd_ptr_q;
    logic          out_ovf_q;

    logic [AW-1:0] addr_eff;
    logic          wr_now;
    logic          os_now;
    logic          cpu_wr_try;
    logic          cpu_wr_commit;
    logic [PW:0]   fifo_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;

    // Transparent-latch equivalent: the address is visible in the same cycle it is driven.
    assign addr_eff = bus_in[7] ? bus_in[AW-1:0] : addr_q;
    assign rdata    = mem[addr_eff];

    // Strobes only count in the data phase, so an address phase ends a held strobe.
    assign wr_now   = !bus_in[7] && !bus_in[5];
    assign os_now   = !bus_in[7] &&  bus_in[4];

    // One commit per strobe assertion; preload takes the store port in a clash.
    assign cpu_wr_try = wr_now && !wr_prev_q && !load_en && !rst;

`ifdef RESP_WRPROT_EN
    logic prot_hit;
    logic wp_err_q;

    assign prot_hit      = cpu_wr_try && (addr_q < PROT_LIMIT);
    assign cpu_wr_commit = cpu_wr_try && !prot_hit;
    assign wp_err        = wp_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_err_q <= 1'b0;
        end else if (prot_hit) begin
            wp_err_q <= 1'b1;
        end
    end
`else
    // PROT_LIMIT stays on the interface so both builds share one parameter list.
    logic unused_prot_limit;

    assign unused_prot_limit = ^PROT_LIMIT;
    assign cpu_wr_commit     = cpu_wr_try;
    assign wp_err            = 1'b0;
`endif

    // FIFO bookkeeping: pointers carry one wrap bit so full and empty are distinguishable.
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? 4'h0 : fifo_mem[rd_ptr_q[PW-1:0]];
    assign out_ovf    = out_ovf_q;

    assign pop      = out_valid && out_ready;
    assign push_req = os_now && !os_prev_q && !rst;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (cpu_wr_commit) begin
            mem[addr_q] <= bus_in[3:0];
        end
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= bus_in[3:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wr_prev_q <= 1'b0;
            os_prev_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            if (bus_in[7]) begin
                addr_q <= bus_in[AW-1:0];
            end
            wr_prev_q <= wr_now;
            os_prev_q <= os_now;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                out_ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_moonbase_bus_responder.sv
// Testbench for moonbase_bus_responder: directed scenarios plus randomized bus traffic,
// each cycle compared against a queue/array reference model of the bus responder.
// Ends with a single CHECKS/ERRORS summary line.

module tb_moonbase_bus_responder;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] bus_in;
    logic [3:0] rdata;
    logic       load_en;
    logic [6:0] load_addr;
    logic [3:0] load_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_ovf;
    logic       wp_err;

    moonbase_bus_responder #(
        .AW         (7),
        .FIFO_DEPTH (DEPTH),
        .PROT_LIMIT (7'h60)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_in    (bus_in),
        .rdata     (rdata),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf),
        .wp_err    (wp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [3:0] m_mem [128];
    logic [6:0] m_addr;
    bit         m_wr_prev;
    bit         m_os_prev;
    logic [3:0] m_q [$];
    bit         m_ovf;
    bit         m_wperr;

`ifdef RESP_WRPROT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr    = '0;
        m_wr_prev = 1'b0;
        m_os_prev = 1'b0;
        m_q.delete();
        m_ovf     = 1'b0;
        m_wperr   = 1'b0;
    endtask

    // One bus cycle: drive after the falling edge, compare combinational outputs,
    // then advance the model across the rising edge.
    task automatic step(input logic [7:0] b, input logic le, input logic [6:0] la,
                        input logic [3:0] ld, input logic rdy);
        logic [6:0] ea;
        bit wr_now, os_now, do_pop, do_push;
        @(negedge clk);
        bus_in    = b;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        out_ready = rdy;
        #1;
        ea = b[7] ? b[6:0] : m_addr;
        check("rdata",     8'(rdata),     8'(m_mem[ea]));
        check("out_valid", 8'(out_valid), 8'(m_q.size() != 0));
        check("out_data",  8'(out_data),  (m_q.size() != 0) ? 8'(m_q[0]) : 8'h00);
        check("out_ovf",   8'(out_ovf),   8'(m_ovf));
        check("wp_err",    8'(wp_err),    8'(m_wperr));
        @(posedge clk);
        wr_now  = !b[7] && !b[5];
        os_now  = !b[7] &&  b[4];
        do_pop  = (m_q.size() != 0) && rdy;
        do_push = os_now && !m_os_prev;
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(b[3:0]);
            else                    m_ovf = 1'b1;
        end
        if (le) begin
            m_mem[la] = ld;
        end else if (wr_now && !m_wr_prev) begin
            if (PROT_ON && (m_addr < 7'h60)) m_wperr = 1'b1;
            else                             m_mem[m_addr] = b[3:0];
        end
        if (b[7]) m_addr = b[6:0];
        m_wr_prev = wr_now;
        m_os_prev = os_now;
    endtask

    task automatic idle(input logic rdy);
        step(8'h20, 1'b0, 7'h00, 4'h0, rdy);
    endtask

    task automatic preload(input logic [6:0] a, input logic [3:0] d);
        step(8'h20, 1'b1, a, d, 1'b0);
    endtask

    // Output strobe carrying d, followed by a released cycle so the next strobe is a fresh edge.
    task automatic strobe(input logic [3:0] d, input logic rdy);
        step({4'h3, d}, 1'b0, 7'h00, 4'h0, rdy);
        idle(1'b0);
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic pulse_reset();
        @(negedge clk);
        bus_in  = 8'h20;
        load_en = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 8'(out_valid), 8'h00);
        check("rst_out_data",  8'(out_data),  8'h00);
        check("rst_out_ovf",   8'(out_ovf),   8'h00);
        check("rst_wp_err",    8'(wp_err),    8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus_in    = 8'h20;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        out_ready = 1'b0;
        model_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = 4'h0;
        #3;
        check("init_out_valid", 8'(out_valid), 8'h00);
        check("init_out_data",  8'(out_data),  8'h00);
        check("init_out_ovf",   8'(out_ovf),   8'h00);
        check("init_wp_err",    8'(wp_err),    8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Give every store location a known value.
        for (int i = 0; i < 128; i++) preload(7'(i), 4'($urandom_range(0, 15)));

        // Preload then read through both address phase and data phase.
        preload(7'h12, 4'hA);
        step(8'h92, 1'b0, 7'h00, 4'h0, 1'b0);
        step(8'h00, 1'b0, 7'h00, 4'h0, 1'b0);
        idle(1'b0);

        // Held write strobe with data changing mid-hold: only the first edge commits.
        preload(7'h70, 4'h3);
        step(8'hF0, 1'b0, 7'h00, 4'h0, 1'b0);
        step(8'h05, 1'b0, 7'h00, 4'h0, 1'b0);
        step(8'h05, 1'b0, 7'h00, 4'h0, 1'b0);
        step(8'h07, 1'b0, 7'h00, 4'h0, 1'b0);
        idle(1'b0);
        step(8'hF0, 1'b0, 7'h00, 4'h0, 1'b0);
        #1;
        check("held_wr_value", 8'(rdata), 8'h05);

        // FIFO fill, overflow drop, then in-order drain.
        for (int d = 1; d <= 4; d++) strobe(4'(d), 1'b0);
        strobe(4'h5, 1'b0);
        #1;
        check("ovf_set",   8'(out_ovf),  8'h01);
        check("full_head", 8'(out_data), 8'h01);
        for (int i = 0; i < 5; i++) idle(1'b1);
        #1;
        check("drained", 8'(out_valid), 8'h00);

        // Mid-run reset with live FIFO entries and sticky overflow; the store survives.
        strobe(4'hA, 1'b0);
        strobe(4'hB, 1'b0);
        preload(7'h30, 4'hC);
        pulse_reset();
        step(8'hB0, 1'b0, 7'h00, 4'h0, 1'b0);
        #1;
        check("mem_kept", 8'(rdata), 8'h0C);

        // Push and pop together on a full FIFO: no drop.
        for (int d = 1; d <= 4; d++) strobe(4'(d + 4), 1'b0);
        step(8'h39, 1'b0, 7'h00, 4'h0, 1'b1);
        idle(1'b0);
        #1;
        check("full_pushpop_ovf",  8'(out_ovf),  8'h00);
        check("full_pushpop_head", 8'(out_data), 8'h06);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Push and pop together on an empty FIFO: the push lands.
        step(8'h3E, 1'b0, 7'h00, 4'h0, 1'b1);
        idle(1'b0);
        #1;
        check("empty_pushpop", 8'(out_data), 8'h0E);
        idle(1'b1);

`ifdef RESP_WRPROT_EN
        step(8'h90, 1'b0, 7'h00, 4'h0, 1'b0);
        step(8'h0F, 1'b0, 7'h00, 4'h0, 1'b0);
        idle(1'b0);
        #1;
        check("wp_err_set", 8'(wp_err), 8'h01);
        step(8'hF0, 1'b0, 7'h00, 4'h0, 1'b0);
        step(8'h09, 1'b0, 7'h00, 4'h0, 1'b0);
        idle(1'b0);
        preload(7'h10, 4'h6);
        step(8'h90, 1'b0, 7'h00, 4'h0, 1'b0);
        #1;
        check("wp_preload", 8'(rdata), 8'h06);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] b;
            logic       le;
            if ($urandom_range(0, 2) == 0) b = {1'b1, 7'($urandom)};
            else                           b = {1'b0, 7'($urandom)};
            le = ($urandom_range(0, 9) == 0);
            step(b, le, 7'($urandom), 4'($urandom), 1'($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 399) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/moonbase_bus_responder.md
Name: moonbase_bus_responder

Overview:
- Memory-side responder for the moonbase_cpu_4bit multiplexed nibble bus. Synthesisable replacement for the bench-side address latch and SRAM.
- Decodes the CPU's 8-bit bus output (address phase / data phase), holds a 128x4 data store and returns read nibbles to the CPU.
- Captures CPU output strobes (bit 4) into a small FIFO drained by a host with valid/ready.
- Provides a host preload port for loading programs while the CPU is held in reset.

Parameters:
- AW, 7, address width; store depth is 2**AW nibbles.
- FIFO_DEPTH, 4, output-capture FIFO entries; power of two, 2..16.
- PROT_LIMIT, 7'h60, write-protect boundary; used only with the optional feature.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bus_in  input  8  CPU io_out. [7]=address phase; [6:0]=address when [7]=1; [3:0]=data, [4]=output strobe (active high), [5]=write strobe (active low) when [7]=0.
- rdata  output  4  read nibble to CPU io_in[5:2]; combinational.
- load_en  input  1  host preload write enable.
- load_addr  input  AW  host preload address.
- load_data  input  4  host preload nibble.
- out_data  output  4  FIFO head nibble.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  host pop; a pop occurs when out_valid&out_ready.
- out_ovf  output  1  sticky: captured nibble dropped because FIFO full.
- wp_err  output  1  sticky write-protect violation; constant 0 without the macro.

Behaviour:
- Reset (async, rst=1):
  - addr_q=0, wr_prev=0, os_prev=0.
  - FIFO empty: out_valid=0, out_data=0.
  - out_ovf=0, wp_err=0.
  - Store contents are not reset and are preserved across a mid-run reset.
- Address latch:
  - addr_eff = bus_in[7] ? bus_in[6:0] : addr_q (transparent-latch equivalent).
  - addr_q <= bus_in[6:0] on every clk edge where bus_in[7]=1; otherwise it holds.
- Read: rdata = mem[addr_eff], combinational, zero latency. During the cycle of a write, rdata shows the old value; the new value appears from the next cycle.
- CPU write:
  - wr_now = !bus_in[7] & !bus_in[5].
  - Commit mem[addr_q] <= bus_in[3:0] on the edge where wr_now & !wr_prev.
  - Exactly one write per strobe assertion, however many cycles it is held.
  - wr_prev <= wr_now every cycle.
- Preload:
  - load_en=1 writes mem[load_addr] <= load_data on the edge.
  - Load has priority: a CPU write commit in the same cycle is discarded (wr_prev still updates).
  - Preload is not subject to write protect.
- Output capture:
  - os_now = !bus_in[7] & bus_in[4].
  - Push bus_in[3:0] on the edge where os_now & !os_prev; os_prev <= os_now.
  - Push while full and no pop in that cycle: nibble dropped, out_ovf <= 1. out_ovf is cleared only by reset.
  - Simultaneous push and pop when full: both take effect, no drop.
  - Simultaneous push and pop when empty: the push is stored; the pop is ignored because out_valid=0.
  - FIFO uses read/write pointers with one extra wrap bit. Count is always 0..FIFO_DEPTH.
  - out_data = head entry, first-in first-out. out_data=0 when empty.
- A phase change (bus_in[7] going 1) during a held strobe de-asserts wr_now/os_now. A fresh 0->1 strobe edge is then required for the next action.

Optional Feature:
- Macro RESP_WRPROT_EN.
- Defined:
  - CPU write commits with addr_q < PROT_LIMIT are suppressed and set sticky wp_err <= 1. Memory is unchanged.
  - Preload writes are unaffected.
  - wp_err clears only on reset.
- Undefined: no address check, all CPU writes commit, wp_err tied 0, no protect logic synthesised.

Test Plan:
- Preload then read: load mem[0x12]=0xA; bus_in=0x92 then 0x00 -> rdata=0xA in both cycles; addr_q=0x12.
- Held write strobe: addr 0x70, then bus_in=0x05 held 3 cycles -> single commit, mem[0x70]=0x5. rdata=old value in the first strobe cycle and 0x5 afterwards. Changing bus_in[3:0] to 0x7 mid-hold leaves mem[0x70]=0x5.
- Output FIFO order and overflow, out_ready=0:
  - Strobes with data 0x1, 0x2, 0x3, 0x4 -> FIFO full.
  - Fifth strobe with 0x5 -> dropped, out_ovf=1.
  - Then out_ready=1 -> pops 1,2,3,4, then out_valid=0.
- Full push+pop: FIFO full, strobe 0x9 with out_ready=1 in the same cycle -> pops head, 0x9 stored at tail, out_ovf stays 0.
- Reset mid-run: mem[0x30]=0xC, 2 FIFO entries, out_ovf=1; assert rst between edges -> outputs clear immediately; after release, address 0x30 reads 0xC.
- RESP_WRPROT_EN defined: CPU write 0xF to addr 0x10 -> mem unchanged, wp_err=1. Write to 0x70 -> commits. Preload to 0x10 -> commits.
